// File: rtl/booth_mul_seq_if.sv
// Byte-wide operand/product bus for booth_mul_seq, shared with the divider slot.
// Exposes the multiplier FSM state on dbg_state for checker binding.
interface booth_mul_seq_if;
  // Protocol: a one-cycle begin_mul in IDLE starts an operation. The bus then
  // carries M on the next edge and Q on the edge after that. Later, fin is high
  // for exactly two cycles: out_bus carries the product high byte, then the low
  // byte. There is no backpressure, and begin_mul outside IDLE is dropped.
  logic       begin_mul;
  logic [7:0] in_bus;
  logic       fin;
  logic [7:0] out_bus;
  logic [2:0] dbg_state;

  modport master (
    output begin_mul,
    output in_bus,
    input  fin,
    input  out_bus,
    input  dbg_state
  );

  modport slave (
    input  begin_mul,
    input  in_bus,
    output fin,
    output out_bus,
    output dbg_state
  );
endinterface

// File: rtl/booth_mul_seq.sv
// Sequential signed 8x8 radix-2 Booth multiplier with a byte-wide in/out bus.
// Optional macro BOOTH_MUL_SKIP_EN: skip the ADD cycle on 00/11 Booth pairs.
module booth_mul_seq (
  input  logic            clk,
  input  logic            rst,
  booth_mul_seq_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LD_M   = 3'd1,
    S_LD_Q   = 3'd2,
    S_ADD    = 3'd3,
    S_SHIFT  = 3'd4,
    S_OUT_HI = 3'd5,
    S_OUT_LO = 3'd6
  } state_t;

  state_t     state;
  logic [8:0] acc;
  logic [8:0] mcand;
  logic [7:0] mplier;
  logic       q_1;
  logic [2:0] cnt;
  logic       fin_r;
  logic [7:0] out_r;

  // Datapath results, computed from the current register contents.
  logic [8:0] acc_sum;
  logic [8:0] acc_dif;
  logic [8:0] acc_sh;
  logic [7:0] mplier_sh;
  logic       q_1_sh;
  logic [1:0] pair_cur;
  logic [1:0] pair_ld;
  logic [1:0] pair_sh;
  state_t     ld_next;
  state_t     sh_next;

  // The 9-bit width keeps -(-128) representable; wrap is modulo 2^9.
  always_comb begin
    acc_sum   = acc + mcand;
    acc_dif   = acc - mcand;
    acc_sh    = {acc[8], acc[8:1]};
    mplier_sh = {acc[0], mplier[7:1]};
    q_1_sh    = mplier[0];
    pair_cur  = {mplier[0], q_1};
    pair_ld   = {bus.in_bus[0], q_1};
    pair_sh   = mplier[1:0];
  end

`ifdef BOOTH_MUL_SKIP_EN
  // Only 01/10 pairs change the accumulator, so other pairs go straight to SHIFT.
  always_comb begin
    ld_next = (pair_ld[1] ^ pair_ld[0]) ? S_ADD : S_SHIFT;
    sh_next = (pair_sh[1] ^ pair_sh[0]) ? S_ADD : S_SHIFT;
  end
`else
  always_comb begin
    ld_next = S_ADD;
    sh_next = S_ADD;
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= S_IDLE;
      acc    <= 9'd0;
      mcand  <= 9'd0;
      mplier <= 8'd0;
      q_1    <= 1'b0;
      cnt    <= 3'd0;
      fin_r  <= 1'b0;
      out_r  <= 8'd0;
    end else begin
      case (state)
        S_IDLE: begin
          fin_r <= 1'b0;
          out_r <= 8'd0;
          if (bus.begin_mul) begin
            state <= S_LD_M;
          end
        end

        S_LD_M: begin
          mcand <= {bus.in_bus[7], bus.in_bus};
          acc   <= 9'd0;
          q_1   <= 1'b0;
          cnt   <= 3'd0;
          state <= S_LD_Q;
        end

        S_LD_Q: begin
          mplier <= bus.in_bus;
          state  <= ld_next;
        end

        S_ADD: begin
          case (pair_cur)
            2'b01:   acc <= acc_sum;
            2'b10:   acc <= acc_dif;
            default: acc <= acc;
          endcase
          state <= S_SHIFT;
        end

        S_SHIFT: begin
          acc    <= acc_sh;
          mplier <= mplier_sh;
          q_1    <= q_1_sh;
          cnt    <= cnt + 3'd1;
          if (cnt == 3'd7) begin
            // Load the high byte now so it is valid during the first fin cycle.
            fin_r <= 1'b1;
            out_r <= acc_sh[7:0];
            state <= S_OUT_HI;
          end else begin
            state <= sh_next;
          end
        end

        S_OUT_HI: begin
          fin_r <= 1'b1;
          out_r <= mplier;
          state <= S_OUT_LO;
        end

        S_OUT_LO: begin
          fin_r <= 1'b0;
          out_r <= 8'd0;
          state <= S_IDLE;
        end

        default: begin
          fin_r <= 1'b0;
          out_r <= 8'd0;
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.fin       = fin_r;
  assign bus.out_bus   = out_r;
  assign bus.dbg_state = state;

endmodule

// File: tb/tb_booth_mul_seq.sv
// Directed self-checking bench for booth_mul_seq (base or BOOTH_MUL_SKIP_EN build).
module tb_booth_mul_seq;

  logic clk;
  logic rst;
  booth_mul_seq_if bus ();

  booth_mul_seq dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // Clock and reset.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;
  logic [7:0] exp_q[$];

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one multiplication. pulse_at: cycle after which begin_mul is pulsed
  // (0 = never). rst_at: edge at which rst is sampled low (0 = never).
  task automatic run_vec(input string name, input logic [7:0] m, input logic [7:0] q,
                         input logic [7:0] hi, input logic [7:0] lo, input int lat,
                         input int pulse_at, input int rst_at);
    int cyc;
    bus.begin_mul = 1'b1;
    tick();                          // edge 0
    bus.begin_mul = 1'b0;
    bus.in_bus    = m;
    tick();                          // edge 1
    bus.in_bus    = q;
    tick();                          // edge 2
    bus.in_bus    = 8'($urandom_range(0, 255));
    cyc = 2;
    if (rst_at == 0) begin
      exp_q.push_back(hi);
      exp_q.push_back(lo);
    end
    while (bus.fin !== 1'b1 && cyc < 40) begin
      bus.begin_mul = (cyc == pulse_at);
      rst           = !((cyc + 1) == rst_at);
      tick();
      cyc++;
      if (cyc == rst_at) begin
        rst = 1'b1;
        bus.begin_mul = 1'b0;
        check({name, "_rst_fin"},   16'(bus.fin),       16'd0);
        check({name, "_rst_out"},   16'(bus.out_bus),   16'd0);
        check({name, "_rst_state"}, 16'(bus.dbg_state), 16'd0);
        return;
      end
    end
    bus.begin_mul = 1'b0;
    check({name, "_lat"}, 16'(cyc), 16'(lat));
    if (bus.fin !== 1'b1) begin
      while (exp_q.size() > 0) void'(exp_q.pop_front());
      return;
    end
    check({name, "_hi"}, 16'(bus.out_bus), 16'(exp_q.pop_front()));
    tick();
    check({name, "_fin_lo"}, 16'(bus.fin), 16'd1);
    check({name, "_lo"}, 16'(bus.out_bus), 16'(exp_q.pop_front()));
    tick();
    check({name, "_fin_end"}, 16'(bus.fin), 16'd0);
    check({name, "_out_end"}, 16'(bus.out_bus), 16'd0);
    check({name, "_idle"}, 16'(bus.dbg_state), 16'd0);
  endtask

  task automatic expect_quiet(input string name, input int cycles);
    int seen = 0;
    for (int i = 0; i < cycles; i++) begin
      tick();
      if (bus.fin === 1'b1) seen++;
    end
    check(name, 16'(seen), 16'd0);
  endtask

  // Directed vectors: M, Q, product high/low byte, latency (base, skip).
  logic [7:0] v_m   [6] = '{8'h07, 8'h80, 8'h7F, 8'hFF, 8'h00, 8'h03};
  logic [7:0] v_q   [6] = '{8'hFD, 8'h80, 8'h7F, 8'h01, 8'h5A, 8'h04};
  logic [7:0] v_hi  [6] = '{8'hFF, 8'h40, 8'h3F, 8'hFF, 8'h00, 8'h00};
  logic [7:0] v_lo  [6] = '{8'hEB, 8'h00, 8'h01, 8'hFF, 8'h00, 8'h0C};
  int         v_lat [6];
`ifdef BOOTH_MUL_SKIP_EN
  initial v_lat = '{13, 11, 12, 12, 16, 12};
`else
  initial v_lat = '{18, 18, 18, 18, 18, 18};
`endif

  initial begin
    rst           = 1'b0;
    bus.begin_mul = 1'b0;
    bus.in_bus    = 8'h00;
    repeat (3) tick();
    check("reset_fin",   16'(bus.fin),       16'd0);
    check("reset_out",   16'(bus.out_bus),   16'd0);
    check("reset_state", 16'(bus.dbg_state), 16'd0);
    rst = 1'b1;
    tick();

    for (int i = 0; i < 5; i++) begin
      run_vec($sformatf("vec%0d", i), v_m[i], v_q[i], v_hi[i], v_lo[i], v_lat[i], 0, 0);
      repeat ($urandom_range(0, 2)) tick();
    end

    // begin_mul pulsed after edge 3 (state SHIFT in both builds for 7 x -3).
    run_vec("ignore", v_m[0], v_q[0], v_hi[0], v_lo[0], v_lat[0], 3, 0);
    expect_quiet("ignore_no_second", 30);

    // Reset sampled low at edge 10, then a fresh run.
    run_vec("abort", v_m[2], v_q[2], v_hi[2], v_lo[2], v_lat[2], 0, 10);
    expect_quiet("abort_no_fin", 25);
    run_vec("fresh", v_m[5], v_q[5], v_hi[5], v_lo[5], v_lat[5], 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
